// File: rtl/trace_field_sequencer.sv
// trace_field_sequencer
//
// Builds one text line per trace cycle. Enabled field requesters are visited in
// ascending index order. Each field's characters are streamed onto a single byte
// output. A separator goes between consecutive enabled fields, and a newline ends
// the line. Characters beyond MAX_CHARS are consumed and dropped, and ovfl is set.
//
// Ports:
//   clk         clock
//   reset       asynchronous reset, active low
//   line_start  begin a new line (accepted only when idle)
//   field_en    field enable mask, sampled on an accepted line_start
//   req_val     per-requester character valid
//   req_rdy     per-requester character consumed this cycle
//   req_char    per-requester character, requester i at [8i+7:8i]
//   req_last    per-requester final character of the field
//   out_val     output byte valid
//   out_rdy     consumer ready
//   out_char    output byte
//   out_eol     marks the newline byte
//   busy        line in progress
//   ovfl        sticky: current/last line was truncated
//
// Optional feature (macro TRACE_FIELD_SEQ_CYCLE_PREFIX_EN): a free-running 16-bit
// cycle counter is latched on line_start. Each line is then prefixed with
// "HHHH: " (uppercase hex), and those bytes count toward the line width.

module trace_field_sequencer #(
  parameter int unsigned NREQS     = 4,
  parameter int unsigned MAX_CHARS = 512,
  parameter logic [7:0]  SEP_CHAR  = 8'h20
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               line_start,
  input  logic [NREQS-1:0]   field_en,
  input  logic [NREQS-1:0]   req_val,
  output logic [NREQS-1:0]   req_rdy,
  input  logic [8*NREQS-1:0] req_char,
  input  logic [NREQS-1:0]   req_last,
  output logic               out_val,
  input  logic               out_rdy,
  output logic [7:0]         out_char,
  output logic               out_eol,
  output logic               busy,
  output logic               ovfl
);

  localparam int unsigned IdxW = (NREQS > 1) ? $clog2(NREQS) : 1;
  localparam int unsigned CntW = $clog2(MAX_CHARS + 1);
  localparam logic [CntW-1:0] MaxCnt = CntW'(MAX_CHARS);

`ifdef TRACE_FIELD_SEQ_CYCLE_PREFIX_EN
  typedef enum logic [2:0] {StIdle, StPrefix, StStream, StSep, StEol} state_e;
`else
  typedef enum logic [2:0] {StIdle, StStream, StSep, StEol} state_e;
`endif

  state_e          state_q;
  logic [NREQS-1:0] mask_q;
  logic [IdxW-1:0] idx_q;
  logic [CntW-1:0] char_cnt_q;

`ifdef TRACE_FIELD_SEQ_CYCLE_PREFIX_EN
  logic [15:0] cyc_q;
  logic [15:0] cyc_lat_q;
  logic [2:0]  pfx_cnt_q;
  logic [7:0]  pfx_byte;

  function automatic logic [7:0] hex_char(input logic [3:0] d);
    return (d < 4'd10) ? (8'h30 + {4'd0, d}) : (8'h37 + {4'd0, d});
  endfunction

  always_comb begin
    pfx_byte = 8'h20;
    unique case (pfx_cnt_q)
      3'd0:    pfx_byte = hex_char(cyc_lat_q[15:12]);
      3'd1:    pfx_byte = hex_char(cyc_lat_q[11:8]);
      3'd2:    pfx_byte = hex_char(cyc_lat_q[7:4]);
      3'd3:    pfx_byte = hex_char(cyc_lat_q[3:0]);
      3'd4:    pfx_byte = 8'h3A;
      default: pfx_byte = 8'h20;
    endcase
  end
`endif

  logic             space;
  logic             cur_val;
  logic             cur_last;
  logic [7:0]       cur_char;
  logic             has_next;
  logic [IdxW-1:0]  next_idx;
  logic [NREQS-1:0] first_src;
  logic             has_first;
  logic [IdxW-1:0]  first_idx;
  logic             cnt_ok;
  logic             start_ok;
  logic             hs;

  always_comb begin
    space    = !out_val || out_rdy;
    cur_val  = 1'b0;
    cur_last = 1'b0;
    cur_char = '0;
    req_rdy  = '0;
    for (int unsigned i = 0; i < NREQS; i++) begin
      if (IdxW'(i) == idx_q) begin
        cur_val  = req_val[i];
        cur_last = req_last[i];
        cur_char = req_char[8*i +: 8];
        if (state_q == StStream) req_rdy[i] = req_val[i] && space;
      end
    end

    // Next enabled field strictly above the current one.
    has_next = 1'b0;
    next_idx = '0;
    for (int unsigned i = 0; i < NREQS; i++) begin
      if (!has_next && mask_q[i] && (IdxW'(i) > idx_q)) begin
        has_next = 1'b1;
        next_idx = IdxW'(i);
      end
    end

    // Lowest enabled field: from the live mask when starting, else the latched one.
    first_src = (state_q == StIdle) ? field_en : mask_q;
    has_first = 1'b0;
    first_idx = '0;
    for (int unsigned i = 0; i < NREQS; i++) begin
      if (!has_first && first_src[i]) begin
        has_first = 1'b1;
        first_idx = IdxW'(i);
      end
    end

    cnt_ok   = char_cnt_q < MaxCnt;
    // busy also covers the cycle after the newline is loaded, so gate on it too.
    start_ok = line_start && (state_q == StIdle) && !busy;
    hs       = (state_q == StStream) && cur_val && space;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= StIdle;
      mask_q     <= '0;
      idx_q      <= '0;
      char_cnt_q <= '0;
      out_val    <= 1'b0;
      out_char   <= '0;
      out_eol    <= 1'b0;
      busy       <= 1'b0;
      ovfl       <= 1'b0;
`ifdef TRACE_FIELD_SEQ_CYCLE_PREFIX_EN
      cyc_q      <= '0;
      cyc_lat_q  <= '0;
      pfx_cnt_q  <= '0;
`endif
    end else begin
`ifdef TRACE_FIELD_SEQ_CYCLE_PREFIX_EN
      cyc_q <= cyc_q + 16'd1;
`endif
      // Consumer took the byte; any load below overrides this.
      if (out_val && out_rdy) begin
        out_val <= 1'b0;
        out_eol <= 1'b0;
      end
      busy <= (state_q != StIdle) || start_ok;

      unique case (state_q)
        StIdle: begin
          if (start_ok) begin
            mask_q     <= field_en;
            char_cnt_q <= '0;
            ovfl       <= 1'b0;
`ifdef TRACE_FIELD_SEQ_CYCLE_PREFIX_EN
            cyc_lat_q  <= cyc_q;
            pfx_cnt_q  <= '0;
            state_q    <= StPrefix;
`else
            if (has_first) begin
              idx_q   <= first_idx;
              state_q <= StStream;
            end else begin
              state_q <= StEol;
            end
`endif
          end
        end
`ifdef TRACE_FIELD_SEQ_CYCLE_PREFIX_EN
        StPrefix: begin
          if (space) begin
            if (cnt_ok) begin
              out_val    <= 1'b1;
              out_char   <= pfx_byte;
              out_eol    <= 1'b0;
              char_cnt_q <= char_cnt_q + 1'b1;
            end else begin
              ovfl <= 1'b1;
            end
            if (pfx_cnt_q == 3'd5) begin
              if (has_first) begin
                idx_q   <= first_idx;
                state_q <= StStream;
              end else begin
                state_q <= StEol;
              end
            end else begin
              pfx_cnt_q <= pfx_cnt_q + 3'd1;
            end
          end
        end
`endif
        StStream: begin
          if (hs) begin
            if (cnt_ok) begin
              out_val    <= 1'b1;
              out_char   <= cur_char;
              out_eol    <= 1'b0;
              char_cnt_q <= char_cnt_q + 1'b1;
            end else begin
              ovfl <= 1'b1;
            end
            if (cur_last) state_q <= has_next ? StSep : StEol;
          end
        end
        StSep: begin
          if (space) begin
            if (cnt_ok) begin
              out_val    <= 1'b1;
              out_char   <= SEP_CHAR;
              out_eol    <= 1'b0;
              char_cnt_q <= char_cnt_q + 1'b1;
            end else begin
              ovfl <= 1'b1;
            end
            idx_q   <= next_idx;
            state_q <= StStream;
          end
        end
        StEol: begin
          // The newline is never counted or dropped.
          if (space) begin
            out_val  <= 1'b1;
            out_char <= 8'h0A;
            out_eol  <= 1'b1;
            state_q  <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_trace_field_sequencer.sv
module tb_trace_field_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;

  // DUT A: 4 requesters, default width
  logic        ls_a;
  logic [3:0]  en_a, val_a, rdy_a, last_a;
  logic [31:0] chr_a;
  logic        ov_a, ordy_a, eol_a, busy_a, ofl_a;
  logic [7:0]  oc_a;

  // DUT B: 2 requesters, 4-character lines
  logic        ls_b;
  logic [1:0]  en_b, val_b, rdy_b, last_b;
  logic [15:0] chr_b;
  logic        ov_b, ordy_b, eol_b, busy_b, ofl_b;
  logic [7:0]  oc_b;

  trace_field_sequencer #(.NREQS(4)) u_dut_a (
    .clk(clk), .reset(reset), .line_start(ls_a), .field_en(en_a),
    .req_val(val_a), .req_rdy(rdy_a), .req_char(chr_a), .req_last(last_a),
    .out_val(ov_a), .out_rdy(ordy_a), .out_char(oc_a), .out_eol(eol_a),
    .busy(busy_a), .ovfl(ofl_a)
  );

  trace_field_sequencer #(.NREQS(2), .MAX_CHARS(4)) u_dut_b (
    .clk(clk), .reset(reset), .line_start(ls_b), .field_en(en_b),
    .req_val(val_b), .req_rdy(rdy_b), .req_char(chr_b), .req_last(last_b),
    .out_val(ov_b), .out_rdy(ordy_b), .out_char(oc_b), .out_eol(eol_b),
    .busy(busy_b), .ovfl(ofl_b)
  );

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Requester models: each field is a short string consumed on req_rdy.
  logic [7:0] fa_dat[4][4];
  int         fa_len[4];
  int         pa[4];
  logic       rld_a = 1'b0;
  logic [7:0] fb_dat[2][4];
  int         fb_len[2];
  int         pb[2];
  logic       rld_b = 1'b0;

  always_comb begin
    val_a = '0;
    last_a = '0;
    chr_a = '0;
    for (int i = 0; i < 4; i++) begin
      val_a[i] = pa[i] < fa_len[i];
      last_a[i] = (pa[i] == fa_len[i] - 1);
      chr_a[8*i +: 8] = fa_dat[i][pa[i][1:0]];
    end
  end

  always_comb begin
    val_b = '0;
    last_b = '0;
    chr_b = '0;
    for (int i = 0; i < 2; i++) begin
      val_b[i] = pb[i] < fb_len[i];
      last_b[i] = (pb[i] == fb_len[i] - 1);
      chr_b[8*i +: 8] = fb_dat[i][pb[i][1:0]];
    end
  end

  always @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (rld_a) pa[i] <= 0;
      else if (rdy_a[i]) pa[i] <= pa[i] + 1;
    end
    for (int i = 0; i < 2; i++) begin
      if (rld_b) pb[i] <= 0;
      else if (rdy_b[i]) pb[i] <= pb[i] + 1;
    end
  end

  // Output monitors
  logic [7:0] cap_a[$];
  int         capc_a[$];
  logic [7:0] cap_b[$];
  int eol_cnt_a = 0, bad_eol_a = 0, busy_cnt_a = 0, rdy02_cnt = 0, eol_cnt_b = 0;

  always @(negedge clk) begin
    if (ov_a && ordy_a) begin
      cap_a.push_back(oc_a);
      capc_a.push_back(cyc);
      if (eol_a) eol_cnt_a <= eol_cnt_a + 1;
      if (eol_a !== (oc_a == 8'h0A)) bad_eol_a <= bad_eol_a + 1;
    end
    if (busy_a) busy_cnt_a <= busy_cnt_a + 1;
    if (rdy_a[0] || rdy_a[2]) rdy02_cnt <= rdy02_cnt + 1;
    if (ov_b && ordy_b) begin
      cap_b.push_back(oc_b);
      if (eol_b) eol_cnt_b <= eol_cnt_b + 1;
    end
  end

  // Newline shown as '|' so a line prints on one row.
  function automatic string str_a(input int base);
    string s = "";
    for (int i = base; i < cap_a.size(); i++)
      s = $sformatf("%s%c", s, (cap_a[i] == 8'h0A) ? 8'h7C : cap_a[i]);
    return s;
  endfunction

  function automatic string str_b(input int base);
    string s = "";
    for (int i = base; i < cap_b.size(); i++)
      s = $sformatf("%s%c", s, (cap_b[i] == 8'h0A) ? 8'h7C : cap_b[i]);
    return s;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_a(input string s0, input string s1, input string s2, input string s3);
    string s[4];
    s = '{s0, s1, s2, s3};
    for (int i = 0; i < 4; i++) begin
      fa_len[i] = s[i].len();
      for (int j = 0; j < s[i].len(); j++) fa_dat[i][j] = s[i][j];
    end
    rld_a = 1'b1;
    tick();
    rld_a = 1'b0;
  endtask

  task automatic load_b(input string s0, input string s1);
    string s[2];
    s = '{s0, s1};
    for (int i = 0; i < 2; i++) begin
      fb_len[i] = s[i].len();
      for (int j = 0; j < s[i].len(); j++) fb_dat[i][j] = s[i][j];
    end
    rld_b = 1'b1;
    tick();
    rld_b = 1'b0;
  endtask

  task automatic start_a(input logic [3:0] mask);
    en_a = mask;
    ls_a = 1'b1;
    tick();
    ls_a = 1'b0;
  endtask

  task automatic start_b(input logic [1:0] mask);
    en_b = mask;
    ls_b = 1'b1;
    tick();
    ls_b = 1'b0;
  endtask

  task automatic wait_eol_a(input int target, input string name);
    int n = 0;
    while (eol_cnt_a < target && n < 100) begin
      tick();
      n++;
    end
    tests++;
    if (eol_cnt_a < target) begin
      fails++;
      $display("FAIL %s_timeout: newlines %0d, want %0d", name, eol_cnt_a, target);
    end
  endtask

  task automatic wait_eol_b(input int target, input string name);
    int n = 0;
    while (eol_cnt_b < target && n < 100) begin
      tick();
      n++;
    end
    tests++;
    if (eol_cnt_b < target) begin
      fails++;
      $display("FAIL %s_timeout: newlines %0d, want %0d", name, eol_cnt_b, target);
    end
  endtask

  task automatic check_str_a(input int base, input string want, input string name);
    string got;
    got = str_a(base);
    tests++;
    if (got != want) begin
      fails++;
      $display("FAIL %s: got \"%s\" want \"%s\"", name, got, want);
    end
  endtask

  task automatic test_reset();
    tests++;
    if ({ov_a, oc_a, eol_a, rdy_a, busy_a, ofl_a} !== 16'h0) begin
      fails++;
      $display("FAIL reset_a: got %h want 0", {ov_a, oc_a, eol_a, rdy_a, busy_a, ofl_a});
    end
    tests++;
    if ({ov_b, oc_b, eol_b, rdy_b, busy_b, ofl_b} !== 14'h0) begin
      fails++;
      $display("FAIL reset_b: got %h want 0", {ov_b, oc_b, eol_b, rdy_b, busy_b, ofl_b});
    end
  endtask

  task automatic test_basic();
    int base, be, bb;
    base = cap_a.size();
    be = eol_cnt_a;
    bb = bad_eol_a;
    load_a("A", "BC", "D", "EF");
    start_a(4'hF);
    wait_eol_a(be + 1, "basic");
    check_str_a(base, "A BC D EF|", "basic_str");
    tests++;
    if (cap_a.size() - base != 10 || capc_a[capc_a.size() - 1] - capc_a[base] != 9) begin
      fails++;
      $display("FAIL basic_rate: got %0d bytes over %0d cycles, want 10 over 9",
               cap_a.size() - base, capc_a[capc_a.size() - 1] - capc_a[base]);
    end
    tests++;
    if (bad_eol_a - bb != 0) begin
      fails++;
      $display("FAIL basic_eol: got %0d misflagged bytes, want 0", bad_eol_a - bb);
    end
  endtask

  task automatic test_masked();
    int base, be, rb;
    base = cap_a.size();
    be = eol_cnt_a;
    rb = rdy02_cnt;
    load_a("Q", "xy", "R", "z");
    start_a(4'b1010);
    wait_eol_a(be + 1, "masked");
    check_str_a(base, "xy z|", "masked_str");
    tests++;
    if (rdy02_cnt - rb != 0) begin
      fails++;
      $display("FAIL masked_rdy: got %0d cycles of req_rdy[0]/[2], want 0", rdy02_cnt - rb);
    end
  endtask

  task automatic test_empty();
    int base, be, bc, bb;
    base = cap_a.size();
    be = eol_cnt_a;
    bb = bad_eol_a;
    load_a("", "", "", "");
    bc = busy_cnt_a;
    start_a(4'h0);
    wait_eol_a(be + 1, "empty");
    repeat (3) tick();
    check_str_a(base, "|", "empty_str");
    tests++;
    if (busy_cnt_a - bc != 2) begin
      fails++;
      $display("FAIL empty_busy: got %0d busy cycles, want 2", busy_cnt_a - bc);
    end
    tests++;
    if (bad_eol_a - bb != 0) begin
      fails++;
      $display("FAIL empty_eol: got %0d misflagged bytes, want 0", bad_eol_a - bb);
    end
  endtask

  task automatic test_backpressure();
    int base, be, n;
    base = cap_a.size();
    be = eol_cnt_a;
    load_a("A", "BC", "D", "EF");
    start_a(4'hF);
    n = 0;
    while (!(ov_a && oc_a == 8'h42) && n < 40) begin
      tick();
      n++;
    end
    tests++;
    if (!(ov_a && oc_a == 8'h42)) begin
      fails++;
      $display("FAIL bp_find: got out_char %h, want 42 valid", oc_a);
    end
    ordy_a = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      tests++;
      if ({ov_a, oc_a, rdy_a} !== {1'b1, 8'h42, 4'h0}) begin
        fails++;
        $display("FAIL bp_hold%0d: got %h want %h", k, {ov_a, oc_a, rdy_a}, {1'b1, 8'h42, 4'h0});
      end
    end
    ordy_a = 1'b1;
    wait_eol_a(be + 1, "bp");
    check_str_a(base, "A BC D EF|", "bp_str");
  endtask

  task automatic test_overflow();
    int base;
    string got;
    base = cap_b.size();
    load_b("abc", "def");
    start_b(2'b11);
    wait_eol_b(eol_cnt_b + 1, "ovf");
    got = str_b(base);
    tests++;
    if (got != "abc |") begin
      fails++;
      $display("FAIL ovf_str: got \"%s\" want \"abc |\"", got);
    end
    tests++;
    if (ofl_b !== 1'b1) begin
      fails++;
      $display("FAIL ovf_flag: got %b want 1", ofl_b);
    end
    load_b("abc", "def");
    start_b(2'b11);
    tests++;
    if (ofl_b !== 1'b0) begin
      fails++;
      $display("FAIL ovf_clear: got %b want 0", ofl_b);
    end
    wait_eol_b(eol_cnt_b + 1, "ovf2");
    repeat (2) tick();
  endtask

  task automatic test_reset_busy();
    int base, be, n;
    base = cap_a.size();
    be = eol_cnt_a;
    load_a("A", "BC", "D", "EF");
    start_a(4'hF);
    repeat (2) tick();
    en_a = 4'h0;
    ls_a = 1'b1;
    tick();
    ls_a = 1'b0;
    wait_eol_a(be + 1, "ignore");
    repeat (10) tick();
    check_str_a(base, "A BC D EF|", "ignore_str");

    base = cap_a.size();
    load_a("A", "BC", "D", "EF");
    start_a(4'hF);
    n = 0;
    while (cap_a.size() < base + 2 && n < 40) begin
      tick();
      n++;
    end
    reset = 1'b0;
    #1;
    tests++;
    if ({ov_a, oc_a, eol_a, rdy_a, busy_a, ofl_a} !== 16'h0) begin
      fails++;
      $display("FAIL midreset: got %h want 0", {ov_a, oc_a, eol_a, rdy_a, busy_a, ofl_a});
    end
    tick();
    reset = 1'b1;
    base = cap_a.size();
    be = eol_cnt_a;
    load_a("A", "BC", "D", "EF");
    start_a(4'hF);
    wait_eol_a(be + 1, "after_reset");
    check_str_a(base, "A BC D EF|", "after_reset_str");
  endtask

  initial begin
    reset = 1'b0;
    ls_a = 1'b0;
    en_a = '0;
    ordy_a = 1'b1;
    ls_b = 1'b0;
    en_b = '0;
    ordy_b = 1'b1;
    repeat (3) tick();
    test_reset();
    reset = 1'b1;
    tick();
    test_basic();
    test_masked();
    test_empty();
    test_backpressure();
    test_overflow();
    test_reset_busy();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
